// File: rtl/fft_peak_detect.sv
// Captures one 16-bin FFT frame, scans one bin per cycle and reports the index of the
// largest squared magnitude with a one-cycle done pulse 17 cycles after the strobe.
module fft_peak_detect #(
  parameter int DW   = 16,
  parameter int MAGW = 2*DW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fft_valid,
  input  logic [2*DW-1:0] fft_d0,
  input  logic [2*DW-1:0] fft_d1,
  input  logic [2*DW-1:0] fft_d2,
  input  logic [2*DW-1:0] fft_d3,
  input  logic [2*DW-1:0] fft_d4,
  input  logic [2*DW-1:0] fft_d5,
  input  logic [2*DW-1:0] fft_d6,
  input  logic [2*DW-1:0] fft_d7,
  input  logic [2*DW-1:0] fft_d8,
  input  logic [2*DW-1:0] fft_d9,
  input  logic [2*DW-1:0] fft_d10,
  input  logic [2*DW-1:0] fft_d11,
  input  logic [2*DW-1:0] fft_d12,
  input  logic [2*DW-1:0] fft_d13,
  input  logic [2*DW-1:0] fft_d14,
  input  logic [2*DW-1:0] fft_d15,
  output logic            busy,
  output logic            done,
  output logic [3:0]      freq,
  output logic            overrun
);

  typedef enum logic [1:0] {IDLE, SCAN, REPORT} state_t;

  state_t                state, state_nx;
  logic                  accept;
  logic [3:0]            idx;
  logic [3:0]            best;
  logic [MAGW-1:0]       max_mag;
  logic [MAGW-1:0]       mag;
  logic                  gt;
  logic [2*DW-1:0]       bank [16];
  logic [2*DW-1:0]       din  [16];
  logic signed [DW-1:0]  re, im;
  logic signed [2*DW-1:0] re_sq, im_sq;

  always_comb begin
    din[0]  = fft_d0;  din[1]  = fft_d1;  din[2]  = fft_d2;  din[3]  = fft_d3;
    din[4]  = fft_d4;  din[5]  = fft_d5;  din[6]  = fft_d6;  din[7]  = fft_d7;
    din[8]  = fft_d8;  din[9]  = fft_d9;  din[10] = fft_d10; din[11] = fft_d11;
    din[12] = fft_d12; din[13] = fft_d13; din[14] = fft_d14; din[15] = fft_d15;
  end

  // Each square is non-negative and at most 2^30, so the unsigned sum cannot overflow.
  always_comb begin
    re    = bank[idx][2*DW-1:DW];
    im    = bank[idx][DW-1:0];
    re_sq = (2*DW)'(re) * (2*DW)'(re);
    im_sq = (2*DW)'(im) * (2*DW)'(im);
    mag   = MAGW'($unsigned(re_sq)) + MAGW'($unsigned(im_sq));
    gt    = (mag > max_mag);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: begin
        if (fft_valid) begin
          accept   = 1'b1;
          state_nx = SCAN;
        end
      end
      SCAN: begin
        busy = 1'b1;
        if (idx == 4'd15) state_nx = REPORT;
      end
      REPORT: begin
        done = 1'b1;
        if (fft_valid) begin
          accept   = 1'b1;
          state_nx = SCAN;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx     <= '0;
      best    <= '0;
      max_mag <= '0;
      freq    <= '0;
      overrun <= 1'b0;
      for (int k = 0; k < 16; k++) bank[k] <= '0;
    end else begin
      if (accept) begin
        bank    <= din;
        idx     <= '0;
        best    <= '0;
        max_mag <= '0;
      end else if (state == SCAN) begin
        if (gt) begin
          max_mag <= mag;
          best    <= idx;
        end
        idx <= idx + 4'd1;
        // Fold the last bin's compare in directly so freq is ready in the REPORT cycle.
        if (idx == 4'd15) freq <= gt ? idx : best;
      end
      if (fft_valid && state == SCAN) overrun <= 1'b1;
    end
  end

endmodule
